i2s_rx: RTL and testbench
=========================

# i2s_rx

I2S receiver: deserializes an external I2S stream (BCK, LRCK, DATA, all driven by an off-chip master) into parallel signed left/right samples in the `clk` domain. It is the receive-side counterpart of the design's I2S transmitter. It feeds stereo audio into the DSP chain, for example as modulation input for an FM exciter, or for transmitter loopback tests. It is a pure slave and never drives BCK or LRCK.

## Interface
- `OUT_WIDTH`, 16: output sample width in bits; MSB-first capture, two's complement.
- `clk` input 1: system clock (73.728 MHz nominal); all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `BCK` input 1: I2S bit clock, asynchronous to `clk`; requires f(BCK) ≤ f(clk)/8.
- `LRCK` input 1: word select; 0 selects left, 1 selects right; asynchronous.
- `DATA` input 1: serial data, asynchronous.
- `out_left` output OUT_WIDTH: last complete left sample.
- `out_right` output OUT_WIDTH: last complete right sample.
- `out_valid` output 1: one-`clk` pulse when a new left/right pair is presented.
- `out_error` output 1: slot-length error flag (see Configuration).

## Operation
- **Input synchronization:** BCK, LRCK and DATA each pass through a 2-FF synchronizer. A third register on BCK provides rise detection. `rise` = BCK_sync & ~BCK_d.
- **Per `rise`:** sample `d` = DATA_sync and `l` = LRCK_sync, and compare against `l_prev`, the `l` captured at the previous `rise`.
- **Normal bit (`l` == `l_prev`):**
  - If `bitcnt` < OUT_WIDTH, shift `d` into the shift register at bit OUT_WIDTH-1-`bitcnt`.
  - `bitcnt` increments and saturates at 63.
  - Bits beyond OUT_WIDTH are discarded (truncation).
- **Transition edge (`l` ≠ `l_prev`):** the I2S 1-BCK delay means `d` is the LSB slot bit of the *previous* channel.
  - Append `d` under the normal-bit rule.
  - Close the slot: the word is the shift register, zero-padded below if the slot was short.
  - Then clear the shift register and `bitcnt`. The next `rise` carries the MSB of the new channel.
- **States:**
  - `HUNT` (reset state): ignore data until the first transition edge, then go to `RUN`.
  - `RUN`: normal capture. The slot partial at reset or startup is never emitted.
- **Left slot closed (`l_prev` = 0):** hold the word in `left_hold`, set `have_left`.
- **Right slot closed (`l_prev` = 1) with `have_left` = 1:**
  - `out_left` ← `left_hold`; `out_right` ← closed word; pulse `out_valid`; clear `have_left`.
- **Right slot closed with `have_left` = 0:** discard the word; no pulse.
- **Reset values:**
  - `out_left` = 0, `out_right` = 0, `out_valid` = 0, `out_error` = 0.
  - State = `HUNT`, `have_left` = 0, `bitcnt` = 0, `l_prev` = 0, synchronizers = 0.
- **Reset asserted mid-slot:** all state clears immediately, and the partial frame is lost. After release, nothing is output until `HUNT` → `RUN` followed by one complete left and one complete right slot.
- **Output stability:** `out_left` and `out_right` change only in the cycle `out_valid` = 1 and are held otherwise.

## Timing
- Detection latency: `rise` is asserted on the 3rd `clk` edge after the first `clk` edge that samples BCK high at the pin.
- Output latency: `out_valid`, `out_left`, `out_right` and `out_error` are registered and update 1 `clk` after the transition-edge `rise`. Total latency from the pin is 4 `clk` cycles, fixed.
- `out_valid` is high for exactly 1 `clk` per stereo frame. There is no back-pressure; the consumer must accept the pulse.
- DATA and LRCK must be stable at the pin for ≥ 3 `clk` cycles around each BCK rising edge. BCK ≤ f(clk)/8 satisfies this for a standard I2S master (changes on the falling edge).

## Configuration
- **`I2S_RX_ERR_EN` defined:**
  - A slot whose total bit count (including its LSB on the transition edge) is < OUT_WIDTH marks the frame bad.
  - `out_error` is set with the `out_valid` pulse of that frame and holds until the next `out_valid`.
  - The short word is still output, zero-padded.
- **`I2S_RX_ERR_EN` undefined:** no checking logic is built; `out_error` is tied to 0. The port exists in both builds.

## Test plan
- Reset, then 3 frames of 32 BCK/slot, OUT_WIDTH = 16, left = 0x1234, right = 0xABCD → exactly 2 or 3 pulses (first frame may be consumed by `HUNT`). Each pulse shows `out_left` = 0x1234, `out_right` = 0xABCD, 4-`clk` latency from the final transition-edge BCK rise, `out_error` = 0.
- 24-bit slots, left = 0x7FFFFF, right = 0x800001 → `out_left` = 0x7FFF, `out_right` = 0x8000 (truncated).
- 12-bit slots, left = 0xABC, right = 0x123 → `out_left` = 0xABC0, `out_right` = 0x1230. `out_error` = 1 with `I2S_RX_ERR_EN` defined, 0 without.
- Start the stream mid-right-slot after reset → no pulse until a full left slot followed by a right slot has been received. Never output a partial word.
- Assert `reset_n` low for 2 `clk` mid-left-slot of a running stream → all outputs 0 immediately. The first pulse after release carries only post-reset, complete-slot data.
- Loopback from the design's I2S transmitter driving a ramp → `out_left` matches the transmitted samples in order, with no dropped or duplicated pulses over 1000 frames.

Source files
------------

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver, deserializes BCK/LRCK/DATA into clk-domain samples.
// Define I2S_RX_ERR_EN to build slot-length checking on out_error.
module i2s_rx #(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 BCK,
    input  logic                 LRCK,
    input  logic                 DATA,
    output logic [OUT_WIDTH-1:0] out_left,
    output logic [OUT_WIDTH-1:0] out_right,
    output logic                 out_valid,
    output logic                 out_error
);

    typedef enum logic {HUNT, RUN} state_t;

    localparam logic [6:0] W7 = 7'(OUT_WIDTH);

    state_t               state_q;
    state_t               state_d;
    logic [2:0]           bck_q;
    logic [1:0]           lrck_q;
    logic [1:0]           data_q;
    logic                 rise_q;
    logic                 d_q;
    logic                 l_q;
    logic                 l_prev;
    logic [5:0]           bitcnt;
    logic [OUT_WIDTH-1:0] sr;
    logic [OUT_WIDTH-1:0] word;
    logic [OUT_WIDTH-1:0] left_hold;
    logic                 have_left;
    logic                 slot_edge;
    logic                 in_bits;
    logic                 close_left;
    logic                 close_pair;

    // Two-stage synchronizers, BCK delay tap, and a registered rise strobe
    // carrying the DATA/LRCK values sampled alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bck_q  <= '0;
            lrck_q <= '0;
            data_q <= '0;
            rise_q <= 1'b0;
            d_q    <= 1'b0;
            l_q    <= 1'b0;
        end else begin
            bck_q  <= {bck_q[1:0], BCK};
            lrck_q <= {lrck_q[0], LRCK};
            data_q <= {data_q[0], DATA};
            rise_q <= bck_q[1] & ~bck_q[2];
            d_q    <= data_q[1];
            l_q    <= lrck_q[1];
        end
    end

    assign slot_edge  = rise_q & (l_q != l_prev);
    assign in_bits    = {1'b0, bitcnt} < W7;
    assign close_left = slot_edge & (state_q == RUN) & ~l_prev;
    assign close_pair = slot_edge & (state_q == RUN) & l_prev & have_left;

    // Shift register with the current bit merged at its MSB-first position.
    always_comb begin
        word = sr;
        if (in_bits)
            word = sr | ({{(OUT_WIDTH-1){1'b0}}, d_q}
                         << (W7 - 7'd1 - {1'b0, bitcnt}));
    end

    // Bit capture per BCK rise; a word-select change ends the slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr     <= '0;
            bitcnt <= '0;
            l_prev <= 1'b0;
        end else if (rise_q) begin
            l_prev <= l_q;
            if (slot_edge) begin
                sr     <= '0;
                bitcnt <= '0;
            end else begin
                sr <= word;
                if (bitcnt != 6'd63)
                    bitcnt <= bitcnt + 6'd1;
            end
        end
    end

    // Framing state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= HUNT;
        else
            state_q <= state_d;
    end

    // Leave HUNT at the first slot boundary; the partial slot is dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT:    if (slot_edge) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = HUNT;
        endcase
    end

    // Pair a closed left slot with the following right slot and publish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            left_hold <= '0;
            have_left <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (close_left) begin
                left_hold <= word;
                have_left <= 1'b1;
            end else if (close_pair) begin
                out_left  <= left_hold;
                out_right <= word;
                out_valid <= 1'b1;
                have_left <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_ERR_EN
    logic short_slot;
    logic left_short;

    assign short_slot = {1'b0, bitcnt} < (W7 - 7'd1);

    // A frame is bad if either of its slots carried fewer than OUT_WIDTH bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_short <= 1'b0;
            out_error  <= 1'b0;
        end else begin
            if (close_left)
                left_short <= short_slot;
            if (close_pair)
                out_error <= left_short | short_slot;
        end
    end
`else
    assign out_error = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed and randomized I2S streams against a slot-level model.
// Expected words/flags come from slot lists, not from the receiver's internals.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        BCK = 1'b0;
    logic        LRCK = 1'b0;
    logic        DATA = 1'b0;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_valid;
    logic        out_error;

    i2s_rx #(.OUT_WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .BCK       (BCK),
        .LRCK      (LRCK),
        .DATA      (DATA),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .out_error (out_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ch;
        logic [31:0] w;
        int          n;
    } slot_t;

    slot_t       slots[$];
    bit          bl[$];
    bit          bd[$];
    logic [15:0] gl[$];
    logic [15:0] gr[$];
    bit          ge[$];
    int          glat[$];
    logic [15:0] el[$];
    logic [15:0] er[$];
    bit          ee[$];
    int          cyc = 0;
    int          tr_cyc = 0;
    int          stab_bad = 0;
    int          nchk = 0;
    int          nerr = 0;
    bit          cur_lr = 1'b0;
    logic [15:0] pl = '0;
    logic [15:0] pr = '0;

    always @(posedge clk) cyc++;

    // Capture every pulse; flag output changes outside a pulse.
    always @(negedge clk) begin
        if (out_valid) begin
            gl.push_back(out_left);
            gr.push_back(out_right);
            ge.push_back(out_error);
            glat.push_back(cyc - tr_cyc);
        end else if (reset_n && (out_left !== pl || out_right !== pr)) begin
            stab_bad++;
        end
        pl = out_left;
        pr = out_right;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] expw(input logic [31:0] w, input int n);
        logic [31:0] m;
        m = (n >= 32) ? w : (w & ((32'd1 << n) - 32'd1));
        if (n >= 16)
            return 16'(m >> (n - 16));
        return 16'(m << (16 - n));
    endfunction

    function automatic bit experr(input int nl, input int nr);
`ifdef I2S_RX_ERR_EN
        return (nl < 16) || (nr < 16);
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        BCK = 1'b0;
        LRCK = 1'b0;
        DATA = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cur_lr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bit(input bit l, input bit d);
        @(negedge clk);
        BCK = 1'b0;
        LRCK = l;
        DATA = d;
        repeat (4) @(negedge clk);
        BCK = 1'b1;
        if (l != cur_lr)
            tr_cyc = cyc;
        cur_lr = l;
        repeat (3) @(negedge clk);
    endtask

    task automatic add_slot(input bit ch, input logic [31:0] w, input int n);
        slot_t s;
        s.ch = ch;
        s.w = w;
        s.n = n;
        slots.push_back(s);
    endtask

    task automatic add_frames(input int nf, input logic [31:0] wl,
                              input logic [31:0] wr, input int n);
        for (int i = 0; i < nf; i++) begin
            add_slot(1'b0, wl, n);
            add_slot(1'b1, wr, n);
        end
    endtask

    // I2S framing: LRCK leads the data by one BCK, so each bit carries the
    // word select of the bit after it.
    task automatic build();
        bit ch[$];
        bl.delete();
        bd.delete();
        foreach (slots[k])
            for (int j = slots[k].n - 1; j >= 0; j--) begin
                bd.push_back(slots[k].w[j]);
                ch.push_back(slots[k].ch);
            end
        for (int p = 0; p < ch.size(); p++)
            bl.push_back((p + 1 < ch.size()) ? ch[p+1] : ~ch[p]);
    endtask

    task automatic send_range(input int a, input int b);
        for (int p = a; p < b; p++)
            send_bit(bl[p], bd[p]);
    endtask

    function automatic int slot_off(input int idx);
        int o = 0;
        for (int k = 0; k < idx; k++)
            o += slots[k].n;
        return o;
    endfunction

    // Slot a is the one in progress at reset: never complete.
    task automatic model(input int a, input int b);
        bit          have = 1'b0;
        logic [15:0] hw = '0;
        int          hn = 0;
        for (int k = a + 1; k <= b; k++) begin
            if (!slots[k].ch) begin
                have = 1'b1;
                hw = expw(slots[k].w, slots[k].n);
                hn = slots[k].n;
            end else if (have) begin
                el.push_back(hw);
                er.push_back(expw(slots[k].w, slots[k].n));
                ee.push_back(experr(hn, slots[k].n));
                have = 1'b0;
            end
        end
    endtask

    task automatic begin_case();
        slots.delete();
        gl.delete();
        gr.delete();
        ge.delete();
        glat.delete();
        el.delete();
        er.delete();
        ee.delete();
        stab_bad = 0;
    endtask

    task automatic end_case(input string tag);
        int n;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        repeat (12) @(negedge clk);
        chk($sformatf("%s.count", tag), gl.size(), el.size());
        n = (gl.size() < el.size()) ? gl.size() : el.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.left%0d", tag, i), gl[i], el[i]);
            chk($sformatf("%s.right%0d", tag, i), gr[i], er[i]);
            chk($sformatf("%s.err%0d", tag, i), ge[i], ee[i]);
            chk($sformatf("%s.lat%0d", tag, i), glat[i], 4);
        end
        chk($sformatf("%s.stable", tag), stab_bad, 0);
    endtask

    task automatic run_all(input string tag);
        build();
        send_range(0, bl.size());
        model(0, slots.size() - 1);
        end_case(tag);
    endtask

    initial begin
        int off;

        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst.left", out_left, 16'h0);
        chk("rst.right", out_right, 16'h0);
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.error", out_error, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst.valid_idle", out_valid, 1'b0);

        begin_case();
        do_reset();
        add_frames(3, 32'h1234_0000, 32'hABCD_0000, 32);
        run_all("slot32");
        chk("slot32.pulses", gl.size(), 2);

        begin_case();
        do_reset();
        add_frames(3, 32'h007F_FFFF, 32'h0080_0001, 24);
        run_all("slot24");

        begin_case();
        do_reset();
        add_frames(3, 32'h0000_0ABC, 32'h0000_0123, 12);
        run_all("slot12");

        begin_case();
        do_reset();
        add_slot(1'b1, $urandom, 7);
        add_frames(1, $urandom, $urandom, 16);
        add_frames(1, $urandom, $urandom, 16);
        run_all("midright");

        begin_case();
        do_reset();
        for (int i = 0; i < 4; i++)
            add_frames(1, $urandom | 32'h1, $urandom | 32'h1, 20);
        build();
        off = slot_off(4) + 9;
        send_range(0, off);
        @(negedge clk);
        BCK = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst.left", out_left, 16'h0);
        chk("midrst.right", out_right, 16'h0);
        chk("midrst.valid", out_valid, 1'b0);
        chk("midrst.error", out_error, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_range(off, bl.size());
        model(0, 3);
        model(4, slots.size() - 1);
        end_case("midrst");

        begin_case();
        do_reset();
        add_frames(1, $urandom, $urandom, 16);
        add_slot(1'b0, $urandom, 15);
        add_slot(1'b1, $urandom, 16);
        add_slot(1'b0, $urandom, 16);
        add_slot(1'b1, $urandom, 17);
        add_slot(1'b0, $urandom, 16);
        add_slot(1'b1, $urandom, 15);
        add_frames(1, $urandom, $urandom, 16);
        for (int i = 0; i < 12; i++) begin
            add_slot(1'b0, $urandom, $urandom_range(8, 32));
            add_slot(1'b1, $urandom, $urandom_range(8, 32));
        end
        run_all("randlen");

        begin_case();
        do_reset();
        for (int i = 0; i < 60; i++)
            add_frames(1, 32'(i), 32'(16'hFFFF - 16'(i)), 16);
        run_all("ramp");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
